// File: rtl/adc_deserializer_align.sv
// adc_deserializer_align
//   Multi-lane serial-to-parallel converter with word-frame alignment.
//   Each data lane and the frame lane shift one bit per clk. Every WIDTH
//   edges (WIDTH+1 after a slip) the assembled words are captured into Q
//   with a one-cycle valid strobe. The frame word is compared against
//   FRAME_PATTERN. A bit-slip state machine delays the word boundary by one
//   bit on every mismatch until the pattern has been seen LOCK_COUNT times
//   in a row.
//
// Ports
//   clk        : bit clock, lanes sampled on the rising edge
//   rst        : asynchronous, active-low reset
//   D          : CHANNELS serial data lanes
//   FR         : serial frame lane
//   align_en   : 1 lets the FSM slip and change lock state, 0 freezes it
//   Q          : CHANNELS*WIDTH parallel words, channel c at Q[c*WIDTH +: WIDTH]
//   valid      : one-cycle strobe, Q updated in the same cycle
//   locked     : frame alignment achieved
//   slip_count : cumulative slips modulo WIDTH
module adc_deserializer_align #(
    parameter int               WIDTH         = 8,
    parameter int               CHANNELS      = 2,
    parameter bit               MSB_FIRST     = 1'b1,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int               LOCK_COUNT    = 4,
    localparam int              SLIP_W        = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          D,
    input  logic                         FR,
    input  logic                         align_en,
    output logic [CHANNELS*WIDTH-1:0]    Q,
    output logic                         valid,
    output logic                         locked,
    output logic [SLIP_W-1:0]            slip_count
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_CONFIRM,
        ST_LOCKED
    } state_t;

    state_t                 state;
    logic [7:0]             match_cnt;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   hold;
    logic [WIDTH-1:0]       sr [CHANNELS];
    logic [WIDTH-1:0]       sr_nxt [CHANNELS];
    logic [WIDTH-1:0]       fr_sr;
    logic [WIDTH-1:0]       fr_nxt;
    logic [CHANNELS*WIDTH-1:0] q_nxt;
    logic                   boundary;
    logic                   match;
    logic                   slip;

    // Insert one received bit according to the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b);
        if (MSB_FIRST)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    // Words including the bit sampled on the current edge, so a boundary
    // capture needs no extra cycle.
    always_comb begin
        q_nxt  = '0;
        fr_nxt = shift_in(fr_sr, FR);
        for (int c = 0; c < CHANNELS; c++) begin
            sr_nxt[c] = shift_in(sr[c], D[c]);
            q_nxt[c*WIDTH +: WIDTH] = sr_nxt[c];
        end
    end

    assign boundary = (bit_cnt == CNT_W'(WIDTH - 1));
    assign match    = (fr_nxt == FRAME_PATTERN);
    // Every mismatching word seen while alignment is enabled costs one slip,
    // whatever state the FSM is in.
    assign slip     = boundary && align_en && !match;

    // Shift registers and word capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++)
                sr[c] <= '0;
            fr_sr <= '0;
            Q     <= '0;
            valid <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++)
                sr[c] <= sr_nxt[c];
            fr_sr <= fr_nxt;
            valid <= boundary;
            if (boundary)
                Q <= q_nxt;
        end
    end

    // Bit counter, slip and alignment FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            hold       <= 1'b0;
            slip_count <= '0;
            match_cnt  <= '0;
            state      <= ST_SEARCH;
            locked     <= 1'b0;
        end else begin
            // A slip parks the counter at 0 for one extra cycle, pushing the
            // next boundary out by exactly one bit.
            if (boundary) begin
                bit_cnt <= '0;
                hold    <= slip;
            end else if (hold) begin
                hold <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (slip)
                slip_count <= (slip_count == SLIP_W'(WIDTH - 1)) ? '0
                                                                 : slip_count + SLIP_W'(1);

            if (boundary && align_en) begin
                case (state)
                    ST_SEARCH: begin
                        if (match) begin
                            match_cnt <= 8'd1;
                            if (LOCK_COUNT == 1) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state  <= ST_CONFIRM;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (match) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= ST_SEARCH;
                        end
                    end
                    ST_LOCKED: begin
                        if (!match) begin
                            match_cnt <= '0;
                            state     <= ST_SEARCH;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        match_cnt <= '0;
                        state     <= ST_SEARCH;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_deserializer_align.sv
module tb_adc_deserializer_align;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int LC = 4;
    localparam int HMAX = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   D = '0;
    logic            FR = 1'b0;
    logic            align_en = 1'b1;
    logic [CH*W-1:0] q_m, q_l;
    logic            valid_m, valid_l, locked_m, locked_l;
    logic [2:0]      slip_m, slip_l;

    int vectors = 0;
    int miscompares = 0;
    int e = 0;

    logic [7:0] pat_fr = 8'hF0;
    logic [7:0] pat_d0 = 8'hA5;
    logic [7:0] pat_d1 = 8'h3C;

    always #5 clk = ~clk;

    adc_deserializer_align #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b1),
                             .FRAME_PATTERN(8'hF0), .LOCK_COUNT(LC)) dut (
        .clk(clk), .rst(rst), .D(D), .FR(FR), .align_en(align_en),
        .Q(q_m), .valid(valid_m), .locked(locked_m), .slip_count(slip_m));

    adc_deserializer_align #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b0),
                             .FRAME_PATTERN(8'hF0), .LOCK_COUNT(LC)) dut_lsb (
        .clk(clk), .rst(rst), .D(D), .FR(FR), .align_en(align_en),
        .Q(q_l), .valid(valid_l), .locked(locked_l), .slip_count(slip_l));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the raw bit history since reset and the list of word boundaries;
    // a word is simply the last W bits before a boundary, and lock is a run
    // of at least LC consecutive matching frame words.
    bit        h [0:2][0:HMAX-1];
    int        m_edge;
    int        nb [2];
    int        run [2];
    int        slips [2];
    logic [15:0] eq [2];
    logic      ev [2];
    logic      el [2];

    function automatic logic [7:0] word_at(input int lane, input int b, input bit msb);
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < W; k++) begin
            if (msb) w[W-1-k] = h[lane][b-W+1+k];
            else     w[k]     = h[lane][b-W+1+k];
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_edge = 0;
            for (int m = 0; m < 2; m++) begin
                nb[m] = W; run[m] = 0; slips[m] = 0;
                eq[m] = '0; ev[m] = 1'b0; el[m] = 1'b0;
            end
        end else begin
            m_edge++;
            if (m_edge < HMAX) begin
                h[0][m_edge] = D[0];
                h[1][m_edge] = D[1];
                h[2][m_edge] = FR;
            end
            for (int m = 0; m < 2; m++) begin
                bit msb;
                msb = (m == 0);
                ev[m] = 1'b0;
                if (m_edge == nb[m]) begin
                    ev[m] = 1'b1;
                    eq[m] = {word_at(1, m_edge, msb), word_at(0, m_edge, msb)};
                    nb[m] = nb[m] + W;
                    if (align_en) begin
                        if (word_at(2, m_edge, msb) == 8'hF0) begin
                            if (run[m] < 1000) run[m]++;
                        end else begin
                            run[m] = 0;
                            slips[m] = (slips[m] + 1) % W;
                            nb[m] = nb[m] + 1;
                        end
                    end
                    el[m] = (run[m] >= LC);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("q_msb",      32'(q_m),      32'(eq[0]));
        check("valid_msb",  32'(valid_m),  32'(ev[0]));
        check("locked_msb", 32'(locked_m), 32'(el[0]));
        check("slip_msb",   32'(slip_m),   32'(slips[0]));
        check("q_lsb",      32'(q_l),      32'(eq[1]));
        check("valid_lsb",  32'(valid_l),  32'(ev[1]));
        check("locked_lsb", 32'(locked_l), 32'(el[1]));
        check("slip_lsb",   32'(slip_l),   32'(slips[1]));
    end

    // ---------------- stimulus ----------------
    // Streams repeat their 8-bit pattern MSB first, starting at edge off+1;
    // earlier bits are 0. flip_at inverts the FR bit of one edge. pulse
    // mode sends a single 1 on D0 at edge 1.
    task automatic run_to(input int target, input int off, input int flip_at, input bit pulse);
        while (e < target) begin
            int ed, pos, idx;
            ed = e + 1;
            if (pulse) begin
                D  = (ed == 1) ? 2'b01 : 2'b00;
                FR = 1'b0;
            end else begin
                pos = ed - 1 - off;
                if (pos < 0) begin
                    D = 2'b00; FR = 1'b0;
                end else begin
                    idx  = pos % 8;
                    FR   = pat_fr[7-idx] ^ (ed == flip_at);
                    D[0] = pat_d0[7-idx];
                    D[1] = pat_d1[7-idx];
                end
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_q",      32'(q_m),      32'h0);
        check("rst_valid",  32'(valid_m),  32'h0);
        check("rst_locked", 32'(locked_m), 32'h0);
        check("rst_slip",   32'(slip_m),   32'h0);
        @(negedge clk);
        @(negedge clk);
        e = 0;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Initial reset
        align_en = 1'b1;
        @(negedge clk);
        do_reset();

        // Aligned pattern
        run_to(7, 0, 0, 0);
        check("s1_no_valid_e7", 32'(valid_m), 32'h0);
        run_to(8, 0, 0, 0);
        check("s1_valid_e8", 32'(valid_m), 32'h1);
        check("s1_q_e8",     32'(q_m),     32'h3CA5);
        check("s1_unlocked_e8", 32'(locked_m), 32'h0);
        run_to(9, 0, 0, 0);
        check("s1_valid_e9", 32'(valid_m), 32'h0);
        run_to(24, 0, 0, 0);
        check("s1_unlocked_e24", 32'(locked_m), 32'h0);
        run_to(32, 0, 0, 0);
        check("s1_locked_e32", 32'(locked_m), 32'h1);
        check("s1_slip_e32",   32'(slip_m),   32'h0);

        // Lock loss: one FR bit inverted in the word ending at edge 48
        run_to(40, 0, 45, 0);
        check("s3_locked_e40", 32'(locked_m), 32'h1);
        run_to(48, 0, 45, 0);
        check("s3_valid_e48",  32'(valid_m),  32'h1);
        check("s3_drop_e48",   32'(locked_m), 32'h0);
        check("s3_slip_e48",   32'(slip_m),   32'h1);
        run_to(136, 0, 45, 0);
        check("s3_unlocked_e136", 32'(locked_m), 32'h0);
        run_to(144, 0, 45, 0);
        check("s3_relock_e144", 32'(locked_m), 32'h1);
        check("s3_slip_e144",   32'(slip_m),   32'h0);

        // Bit order: single 1 on D0 at edge 1
        do_reset();
        run_to(8, 0, 0, 1);
        check("s5_msb_first", 32'(q_m[7:0]), 32'h80);
        check("s5_lsb_first", 32'(q_l[7:0]), 32'h01);

        // align_en=0 with 3-bit offset, then enable
        do_reset();
        align_en = 1'b0;
        run_to(64, 3, 0, 0);
        check("s4_valid_e64",  32'(valid_m),  32'h1);
        check("s4_slip_e64",   32'(slip_m),   32'h0);
        check("s4_locked_e64", 32'(locked_m), 32'h0);
        align_en = 1'b1;
        run_to(99, 3, 0, 0);
        check("s4_slip_e99",   32'(slip_m),   32'h3);
        check("s4_q_e99",      32'(q_m),      32'h3CA5);
        run_to(123, 3, 0, 0);
        check("s4_locked_e123", 32'(locked_m), 32'h1);

        // Offset 3 with alignment enabled
        do_reset();
        align_en = 1'b1;
        run_to(26, 3, 0, 0);
        check("s2_slip_e26", 32'(slip_m), 32'h3);
        run_to(35, 3, 0, 0);
        check("s2_valid_e35",  32'(valid_m),  32'h1);
        check("s2_q_e35",      32'(q_m),      32'h3CA5);
        check("s2_unlocked_e35", 32'(locked_m), 32'h0);
        run_to(59, 3, 0, 0);
        check("s2_locked_e59", 32'(locked_m), 32'h1);
        check("s2_slip_e59",   32'(slip_m),   32'h3);

        // Reset mid-word while locked (counter at 4 after edge 63)
        run_to(63, 3, 0, 0);
        check("s6_locked_pre", 32'(locked_m), 32'h1);
        do_reset();
        run_to(8, 0, 0, 0);
        check("s6_valid_e8", 32'(valid_m), 32'h1);
        check("s6_q_e8",     32'(q_m),     32'h3CA5);
        run_to(32, 0, 0, 0);
        check("s6_locked_e32", 32'(locked_m), 32'h1);
        check("s6_slip_e32",   32'(slip_m),   32'h0);

        run_to(40, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_deserializer_align.md
# adc_deserializer_align

Parametrised multi-lane serial-to-parallel converter with automatic word-frame alignment for the ADC front end. Every lane, plus one frame lane carrying a fixed training pattern, is sampled once per clk edge. The block assembles WIDTH-bit words per channel and word-aligns all lanes with a bit-slip state machine. It reports lock status and emits a one-cycle valid strobe per word to downstream servo logic.

## Interface
- WIDTH, 8, bits per word; legal range 2..16
- CHANNELS, 2, number of data lanes; legal range 1..16
- MSB_FIRST, 1, 1: first received bit lands in Q MSB; 0: first received bit lands in LSB
- FRAME_PATTERN, 8'hF0 (WIDTH bits), expected frame-lane word when aligned; must have WIDTH distinct rotations
- LOCK_COUNT, 4, consecutive matching frame words required to declare lock; legal range 1..255
- clk  in  1  bit clock; all lanes sampled on the rising edge
- rst  in  1  asynchronous, active-low reset
- D  in  CHANNELS  serial data lanes, one bit per lane per clk
- FR  in  1  serial frame lane
- align_en  in  1  1: FSM may slip and change lock state; 0: FSM and slip frozen
- Q  out  CHANNELS*WIDTH  parallel words; channel c occupies Q[c*WIDTH +: WIDTH]
- valid  out  1  one-cycle strobe; Q is updated in the same cycle
- locked  out  1  frame alignment achieved
- slip_count  out  clog2(WIDTH), minimum 1  cumulative slips modulo WIDTH

## Operation
- Per lane (D and FR): shift register shifts every clk. MSB_FIRST=1 shifts left with the new bit entering bit 0. MSB_FIRST=0 shifts right with the new bit entering bit WIDTH-1.
- Bit counter runs 0..WIDTH-1 and wraps. A word boundary is the edge on which the counter equals WIDTH-1.
- At a boundary:
  - Capture the assembled words, including the bit sampled on that edge, into Q.
  - Assert valid for the following cycle.
  - Compare the assembled frame word with FRAME_PATTERN.
- Slip: the counter holds at 0 for one extra cycle, so the next boundary arrives WIDTH+1 cycles later. slip_count increments modulo WIDTH. valid is still emitted for the slipping word.
- FSM states, evaluated only at boundaries and only while align_en=1:
  - SEARCH, mismatch: slip and stay in SEARCH.
  - SEARCH, match: go to CONFIRM with match_cnt=1. If LOCK_COUNT=1, go directly to LOCKED.
  - CONFIRM, match: increment match_cnt. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - CONFIRM, mismatch: clear match_cnt, slip, go to SEARCH.
  - LOCKED, match: stay in LOCKED.
  - LOCKED, mismatch: drop locked, clear match_cnt, slip, go to SEARCH.
- align_en=0: state, match_cnt and slip_count hold. No slips occur. Words and valid continue every WIDTH cycles.
- Reset (asynchronous, mid-operation included):
  - Q=0, valid=0, locked=0, slip_count=0.
  - Counter=0, match_cnt=0, state SEARCH, shift registers cleared.
  - A partial word in flight at reset is discarded.

## Timing
- Latency: the last bit of a word is sampled at edge N. Q, valid and locked update at edge N, visible in the cycle after that edge. Q holds until the next boundary.
- First boundary is the WIDTH-th rising edge after rst deasserts. Q then holds the bits from edges 1..WIDTH.
- Boundary spacing is WIDTH edges, or WIDTH+1 edges after a slip.
- locked rises with the valid of the LOCK_COUNT-th consecutive matching word. It falls with the valid of the first mismatching word.
- valid is never high on two consecutive cycles when WIDTH is at least 2.

## Test plan
1. Aligned pattern. WIDTH=8, CHANNELS=2. FR repeats 8'hF0 from edge 1. D0 repeats 8'hA5 and D1 repeats 8'h3C. Response: valid at edges 8, 16, 24, 32. Q={8'h3C,8'hA5}. locked rises at edge 32. slip_count=0.
2. Offset 3. Same streams delayed by 3 bit periods. Response: 3 slips, slip_count=3, locked asserted after 4 further matching words, Q={8'h3C,8'hA5} from the first matching word on.
3. Lock loss. After lock, invert one FR bit in a single word. Response: locked drops with that word's valid and slip_count increments. The FSM resumes searching, and locked reasserts once alignment is regained.
4. align_en=0 with a 3-bit offset. Response: valid every 8 cycles, no slips, slip_count=0, locked=0 indefinitely. Raising align_en then produces lock as in scenario 2.
5. MSB_FIRST=0. D0 sends bits 1,0,0,0,0,0,0,0. Response: Q[7:0]=8'h01. The same stimulus with MSB_FIRST=1 gives 8'h80.
6. Reset mid-operation. Assert rst while locked and mid-word, at counter value 4. Response: all outputs 0 immediately. After release, the first valid occurs at edge 8 and the lock sequence repeats as in scenario 1.
